// File: rtl/range_load_sequencer.sv
// Range-counter load sequencer: walks a table of turn-on counts once per scanline and
// strobes each enabled range counter in turn. Define RANGE_LOAD_SHADOW_EN for a frame-swapped shadow table.
module range_load_sequencer #(
    parameter int NUM_RANGES    = 4,
    parameter int INDEX_WIDTH   = 2,
    parameter int COUNTER_WIDTH = 10
) (
    input  logic                     clock,
    input  logic                     reset,
    input  logic                     wr_valid,
    output logic                     wr_ready,
    input  logic [INDEX_WIDTH-1:0]   wr_index,
    input  logic [COUNTER_WIDTH-1:0] wr_on_count,
    input  logic                     wr_enable,
    input  logic                     line_start,
    input  logic                     frame_start,
    output logic [NUM_RANGES-1:0]    load_strobe,
    output logic [COUNTER_WIDTH-1:0] on_count,
    output logic                     busy,
    output logic                     done,
    output logic                     overrun
);

    // One extra count so the scan index can reach NUM_RANGES, which marks the end of the walk.
    localparam int SCAN_WIDTH = $clog2(NUM_RANGES + 1);

    typedef enum logic [1:0] {IDLE, SCAN, DONE} state_t;

    typedef struct packed {
        logic                     enable;
        logic [COUNTER_WIDTH-1:0] count;
    } entry_t;

    state_t                  state;
    logic [SCAN_WIDTH-1:0]   scan_index;
    logic [SCAN_WIDTH-1:0]   scan_pos;
    entry_t                  active_table [NUM_RANGES];
    entry_t                  view_table   [NUM_RANGES];
    entry_t                  sel_entry;
    logic [NUM_RANGES-1:0]   sel_onehot;
    logic                    wr_hit;

`ifdef RANGE_LOAD_SHADOW_EN
    entry_t shadow_table [NUM_RANGES];
    entry_t shadow_next  [NUM_RANGES];
    logic   copy_pending;
    logic   copy_now;

    assign wr_ready = 1'b1;
    assign copy_now = (state == IDLE) && (frame_start || copy_pending);
`else
    logic unused_frame_start;

    assign wr_ready           = (state == IDLE);
    assign unused_frame_start = frame_start;
`endif

    // Out-of-range indices complete the handshake but never touch the table.
    assign wr_hit = wr_valid && wr_ready && (int'(wr_index) < NUM_RANGES);

    // view_table is what the active table will hold after this edge, so a write or
    // bank copy landing together with line_start is already visible to entry 0.
    always_comb begin
        for (int k = 0; k < NUM_RANGES; k++) begin
`ifdef RANGE_LOAD_SHADOW_EN
            shadow_next[k] = shadow_table[k];
            if (wr_hit && wr_index == INDEX_WIDTH'(k))
                shadow_next[k] = '{enable: wr_enable, count: wr_on_count};
            view_table[k] = copy_now ? shadow_next[k] : active_table[k];
`else
            view_table[k] = active_table[k];
            if (wr_hit && wr_index == INDEX_WIDTH'(k))
                view_table[k] = '{enable: wr_enable, count: wr_on_count};
`endif
        end
    end

    // NOTE: every variable assigned here gets a default first, so no path can leave
    // one unassigned and infer a latch.
    always_comb begin
        scan_pos   = (state == SCAN) ? scan_index : '0;
        sel_entry  = '0;
        sel_onehot = '0;
        for (int k = 0; k < NUM_RANGES; k++) begin
            if (scan_pos == SCAN_WIDTH'(k)) begin
                sel_entry     = view_table[k];
                sel_onehot[k] = 1'b1;
            end
        end
    end

    // NOTE: sequential state uses non-blocking assignments only, so every register
    // samples pre-edge values regardless of statement order.
    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state       <= IDLE;
            scan_index  <= '0;
            load_strobe <= '0;
            on_count    <= '0;
            busy        <= 1'b0;
            done        <= 1'b0;
            overrun     <= 1'b0;
            // NOTE: the table is reset explicitly; it is a handful of flops, not a RAM,
            // and a sequence right after reset must see every entry disabled.
            for (int k = 0; k < NUM_RANGES; k++) active_table[k] <= '0;
`ifdef RANGE_LOAD_SHADOW_EN
            for (int k = 0; k < NUM_RANGES; k++) shadow_table[k] <= '0;
            copy_pending <= 1'b0;
`endif
        end else begin
            for (int k = 0; k < NUM_RANGES; k++) active_table[k] <= view_table[k];
`ifdef RANGE_LOAD_SHADOW_EN
            for (int k = 0; k < NUM_RANGES; k++) shadow_table[k] <= shadow_next[k];
            if (copy_now)
                copy_pending <= 1'b0;
            else if (frame_start)
                copy_pending <= 1'b1;
`endif
            load_strobe <= '0;
            done        <= 1'b0;
            overrun     <= 1'b0;

            case (state)
                IDLE: begin
                    if (line_start) begin
                        state      <= SCAN;
                        busy       <= 1'b1;
                        scan_index <= SCAN_WIDTH'(1);
                        if (sel_entry.enable) begin
                            load_strobe <= sel_onehot;
                            on_count    <= sel_entry.count;
                        end
                    end
                end

                SCAN: begin
                    overrun <= line_start;
                    if (scan_index == SCAN_WIDTH'(NUM_RANGES)) begin
                        state      <= DONE;
                        busy       <= 1'b0;
                        done       <= 1'b1;
                        scan_index <= '0;
                    end else begin
                        scan_index <= scan_index + SCAN_WIDTH'(1);
                        if (sel_entry.enable) begin
                            load_strobe <= sel_onehot;
                            on_count    <= sel_entry.count;
                        end
                    end
                end

                DONE: begin
                    overrun <= line_start;
                    state   <= IDLE;
                end

                default: begin
                    state      <= IDLE;
                    busy       <= 1'b0;
                    scan_index <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_range_load_sequencer.sv
// Scoreboard bench for range_load_sequencer: expected per-cycle outputs are queued when
// stimulus is driven and compared when the cycle is observed.
module tb_range_load_sequencer;

    localparam int N  = 4;
    localparam int IW = 2;
    localparam int CW = 10;
`ifdef RANGE_LOAD_SHADOW_EN
    localparam bit SHADOW = 1'b1;
`else
    localparam bit SHADOW = 1'b0;
`endif

    logic          clock = 1'b0;
    logic          reset;
    logic          wr_valid;
    logic          wr_ready;
    logic [IW-1:0] wr_index;
    logic [CW-1:0] wr_on_count;
    logic          wr_enable;
    logic          line_start;
    logic          frame_start;
    logic [N-1:0]  load_strobe;
    logic [CW-1:0] on_count;
    logic          busy;
    logic          done;
    logic          overrun;

    range_load_sequencer #(.NUM_RANGES(N), .INDEX_WIDTH(IW), .COUNTER_WIDTH(CW)) dut (
        .clock(clock), .reset(reset),
        .wr_valid(wr_valid), .wr_ready(wr_ready), .wr_index(wr_index),
        .wr_on_count(wr_on_count), .wr_enable(wr_enable),
        .line_start(line_start), .frame_start(frame_start),
        .load_strobe(load_strobe), .on_count(on_count),
        .busy(busy), .done(done), .overrun(overrun)
    );

    always #5 clock = ~clock;

    typedef struct {
        logic [N-1:0]  strobe;
        logic [CW-1:0] cnt;
        logic          busy;
        logic          done;
        logic          overrun;
    } rec_t;

    rec_t          exp_q[$];
    logic [CW-1:0] act_cnt [N];
    logic          act_en  [N];
    logic [CW-1:0] sh_cnt  [N];
    logic          sh_en   [N];
    logic [CW-1:0] last_cnt;
    int            passed = 0;
    int            total  = 0;
    int            cyc    = 0;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) begin
            passed++;
        end else begin
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic clear_model();
        for (int k = 0; k < N; k++) begin
            act_cnt[k] = '0; act_en[k] = 1'b0;
            sh_cnt[k]  = '0; sh_en[k]  = 1'b0;
        end
        last_cnt = '0;
    endtask

    task automatic push_idle();
        rec_t r;
        r = '{strobe: '0, cnt: last_cnt, busy: 1'b0, done: 1'b0, overrun: 1'b0};
        exp_q.push_back(r);
    endtask

    // Full line sequence from the model's active table: N strobe cycles, done, then idle.
    task automatic push_seq();
        rec_t r;
        for (int k = 0; k < N; k++) begin
            r = '{strobe: '0, cnt: last_cnt, busy: 1'b1, done: 1'b0, overrun: 1'b0};
            if (act_en[k]) begin
                r.strobe[k] = 1'b1;
                last_cnt    = act_cnt[k];
                r.cnt       = last_cnt;
            end
            exp_q.push_back(r);
        end
        r = '{strobe: '0, cnt: last_cnt, busy: 1'b0, done: 1'b1, overrun: 1'b0};
        exp_q.push_back(r);
        push_idle();
    endtask

    // Advance one cycle, drop single-cycle inputs, compare against the next queued record.
    task automatic tick_check();
        rec_t r;
        @(negedge clock);
        cyc++;
        line_start  = 1'b0;
        frame_start = 1'b0;
        wr_valid    = 1'b0;
        if (exp_q.size() == 0) begin
            total++;
            $error("FAIL scoreboard_empty: observed cycle %0d with no expectation queued", cyc);
        end else begin
            r = exp_q.pop_front();
            check($sformatf("strobe@%0d", cyc),   32'(load_strobe), 32'(r.strobe));
            check($sformatf("on_count@%0d", cyc), 32'(on_count),    32'(r.cnt));
            check($sformatf("busy@%0d", cyc),     32'(busy),        32'(r.busy));
            check($sformatf("done@%0d", cyc),     32'(done),        32'(r.done));
            check($sformatf("overrun@%0d", cyc),  32'(overrun),     32'(r.overrun));
        end
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) tick_check();
    endtask

    // Present a write for the coming edge and record it in the model if the handshake completes.
    task automatic set_write(input int idx, input int cnt, input logic en, input logic exp_ready);
        wr_valid    = 1'b1;
        wr_index    = IW'(idx);
        wr_on_count = CW'(cnt);
        wr_enable   = en;
        #1;
        check($sformatf("wr_ready@%0d", cyc), 32'(wr_ready), 32'(exp_ready));
        if (exp_ready && idx < N) begin
            if (SHADOW) begin
                sh_cnt[idx] = CW'(cnt); sh_en[idx] = en;
            end else begin
                act_cnt[idx] = CW'(cnt); act_en[idx] = en;
            end
        end
    endtask

    task automatic commit();
`ifdef RANGE_LOAD_SHADOW_EN
        frame_start = 1'b1;
        push_idle();
        tick_check();
        for (int k = 0; k < N; k++) begin
            act_cnt[k] = sh_cnt[k]; act_en[k] = sh_en[k];
        end
`endif
    endtask

    initial begin
        reset       = 1'b1;
        wr_valid    = 1'b0;
        wr_index    = '0;
        wr_on_count = '0;
        wr_enable   = 1'b0;
        line_start  = 1'b0;
        frame_start = 1'b0;
        clear_model();

        repeat (3) @(negedge clock);
        check("reset_strobe",   32'(load_strobe), 32'(0));
        check("reset_on_count", 32'(on_count),    32'(0));
        check("reset_busy",     32'(busy),        32'(0));
        check("reset_done",     32'(done),        32'(0));
        check("reset_overrun",  32'(overrun),     32'(0));
        check("reset_wr_ready", 32'(wr_ready),    32'(1));
        reset = 1'b0;

        // Fill all entries enabled, then one full sequence.
        for (int k = 0; k < N; k++) begin
            set_write(k, 100 * (k + 1), 1'b1, 1'b1);
            push_idle();
            tick_check();
        end
        commit();
        line_start = 1'b1;
        push_seq();
        drain(N + 2);

        // Entry 2 disabled: its slot is consumed without a strobe, done timing unchanged.
        set_write(2, 300, 1'b0, 1'b1);
        push_idle();
        tick_check();
        commit();
        line_start = 1'b1;
        push_seq();
        drain(N + 2);

        // Write during SCAN is refused unless the shadow table is present.
        line_start = 1'b1;
        push_seq();
        tick_check();
        set_write(2, 999, 1'b1, SHADOW);
        drain(N + 1);

        // Write coinciding with line_start is seen by the same sequence.
        set_write(1, 555, 1'b1, 1'b1);
        line_start = 1'b1;
        push_seq();
        drain(N + 2);

        // Second line_start two cycles in: overrun pulse, single done.
        line_start = 1'b1;
        push_seq();
        drain(2);
        line_start = 1'b1;
        exp_q[0].overrun = 1'b1;
        drain(N);

        // Reset mid-sequence clears outputs asynchronously and empties the table.
        line_start = 1'b1;
        push_seq();
        drain(2);
        reset = 1'b1;
        #1;
        check("async_reset_strobe",   32'(load_strobe), 32'(0));
        check("async_reset_busy",     32'(busy),        32'(0));
        check("async_reset_on_count", 32'(on_count),    32'(0));
        exp_q.delete();
        clear_model();
        for (int i = 0; i < 3; i++) begin
            @(negedge clock);
            check($sformatf("reset_hold_done%0d", i), 32'(done), 32'(0));
        end
        reset = 1'b0;
        line_start = 1'b1;
        push_seq();
        drain(N + 2);

`ifdef RANGE_LOAD_SHADOW_EN
        // Shadow bank: write while busy is held back until a frame_start swap.
        set_write(0, 50, 1'b1, 1'b1);
        push_idle();
        tick_check();
        commit();
        line_start = 1'b1;
        push_seq();
        tick_check();
        set_write(0, 123, 1'b1, 1'b1);
        tick_check();
        frame_start = 1'b1;
        drain(N);
        for (int k = 0; k < N; k++) begin
            act_cnt[k] = sh_cnt[k]; act_en[k] = sh_en[k];
        end
        line_start = 1'b1;
        push_seq();
        drain(N + 2);
`endif

        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/range_load_sequencer.md
Name: range_load_sequencer

Overview:
Holds the turn-on positions of NUM_RANGES range counters (ball, paddle, brick columns) and reloads them once per scanline. The game logic writes entries through a valid/ready port. A line_start pulse in horizontal blanking makes the sequencer walk the table and issue one load strobe per enabled range counter, with that counter's on_count on a shared bus. It sits between game-state logic and the bank of range counters in the video path.

Parameters:
NUM_RANGES, 4, number of range counters sequenced (1..16)
INDEX_WIDTH, 2, width of write index; must satisfy 2**INDEX_WIDTH >= NUM_RANGES
COUNTER_WIDTH, 10, width of on_count values (matches the pixel counter)

Ports:
clock  in  1  system clock, rising edge
reset  in  1  asynchronous, active-high reset
wr_valid  in  1  table write request
wr_ready  out  1  table write accepted when wr_valid && wr_ready
wr_index  in  INDEX_WIDTH  entry to write
wr_on_count  in  COUNTER_WIDTH  turn-on count for the entry
wr_enable  in  1  entry enable bit written with the count
line_start  in  1  single-cycle pulse; starts a load sequence
frame_start  in  1  single-cycle pulse; bank swap (SHADOW_EN only)
load_strobe  out  NUM_RANGES  one-hot load to range counter k
on_count  out  COUNTER_WIDTH  count for the strobed counter
busy  out  1  high while a sequence is in progress
done  out  1  single-cycle pulse after the last entry
overrun  out  1  single-cycle pulse when line_start is dropped

Behaviour:
- Clock and reset: one clock domain. Reset is asynchronous and active-high.
- Reset state: state=IDLE; all entries on_count=0, enable=0; load_strobe=0, on_count=0, busy=0, done=0, overrun=0; scan index=0.
- Reset mid-sequence: the sequence aborts immediately. No further strobes.
- FSM states: IDLE, SCAN, DONE.
- IDLE -> SCAN: on line_start.
- SCAN: one entry per cycle, index 0..NUM_RANGES-1.
  - Entry enabled: load_strobe[index]=1 and on_count=entry value, both registered.
  - Entry disabled: the cycle is consumed with load_strobe=0. Latency is fixed regardless of enables.
  - After the last index, go to DONE.
- DONE: done=1 for one cycle, then return to IDLE.
- Timing: line_start at cycle t gives entry k's strobe at t+1+k and done at t+1+NUM_RANGES. busy=1 from t+1 through t+NUM_RANGES.
- on_count holds its last driven value when no strobe is active.
- Outputs: all registered except wr_ready.
- line_start while busy or in DONE: ignored, overrun=1 for one cycle, the running sequence is unaffected.
- Writes (without SHADOW_EN): wr_ready = (state==IDLE).
  - A write accepted in the same cycle as line_start updates the entry first, so the sequence uses the new value.
  - wr_index >= NUM_RANGES: accepted, data dropped.
- Single-range case: NUM_RANGES=1 needs no special casing; a sequence is strobe then done.

Optional Feature:
RANGE_LOAD_SHADOW_EN
- Defined:
  - A second, shadow table receives all writes, and wr_ready is constantly 1.
  - frame_start copies the whole shadow table into the active table in one cycle if state==IDLE.
  - If frame_start arrives while busy or in DONE, the copy is deferred to the first IDLE cycle. A line_start in that same cycle sees the copied values.
  - Reset clears both tables.
- Undefined: frame_start is ignored, there is a single table, and wr_ready behaves as in Behaviour.

Test Plan:
- Reset, write entries 0..3 = 100, 200, 300, 400 all enabled, line_start at t -> load_strobe = 0001, 0010, 0100, 1000 at t+1..t+4 with on_count 100..400; done at t+5; busy high t+1..t+4.
- Entry 2 written with enable=0, line_start -> no strobe at t+3, done still at t+5.
- Write attempted during SCAN -> wr_ready=0 and the table is unchanged. Write to index 1 = 555 in the same cycle as line_start -> on_count=555 at t+2.
- line_start again at t+2 -> overrun pulse at t+3, only one done at t+5.
- Reset asserted at t+2 -> strobes cleared asynchronously, no done. After release, line_start gives all entries disabled and no strobes.
- SHADOW_EN: write entry 0=123 while busy (accepted), line_start -> old value strobed. frame_start, then line_start -> 123 strobed at t+1.
